// File: rtl/fsm_striping_ctrl.sv
// Link control FSM for the 4-lane byte striper.
// Sequences RESET/INIT/IDLE/ACTIVE/ERROR and deals bytes round-robin to lanes.
module fsm_striping_ctrl #(
   parameter int DATA_W = 8,
   parameter int TH_W   = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              init,
   input  logic [TH_W-1:0]   th_high_in,
   input  logic [TH_W-1:0]   th_low_in,
   input  logic [3:0]        fifo_empty,
   input  logic [3:0]        fifo_error,
   input  logic              valid_in,
   input  logic [DATA_W-1:0] data_in,
   output logic [TH_W-1:0]   th_high_out,
   output logic [TH_W-1:0]   th_low_out,
   output logic [2:0]        state,
   output logic              idle_out,
   output logic              active_out,
   output logic [3:0]        error_out,
   output logic [3:0]        valid_out,
   output logic [DATA_W-1:0] data_out,
   output logic [1:0]        lane_sel
);

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_INIT   = 3'd1,
      S_IDLE   = 3'd2,
      S_ACTIVE = 3'd3,
      S_ERROR  = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [TH_W-1:0]     r_th_high;
   logic [TH_W-1:0]     r_th_low;
   logic                r_idle;
   logic                r_active;
   logic [3:0]          r_err;
   logic [3:0]          r_valid;
   logic [DATA_W-1:0]   r_data;
   logic [1:0]          r_lane;
   logic                w_err;
   logic                w_accept;

   assign w_err    = |fifo_error;
   assign w_accept = valid_in &&
                     ((r_state == S_IDLE) || (r_state == S_ACTIVE));

   // Next-state: lane error beats init, init beats empty-flag moves
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_RESET: w_next = S_INIT;
         S_INIT: begin
            if (w_err)     w_next = S_ERROR;
            else if (init) w_next = S_INIT;
            else           w_next = S_IDLE;
         end
         S_IDLE: begin
            if (w_err)                     w_next = S_ERROR;
            else if (init)                 w_next = S_INIT;
            else if (fifo_empty != 4'hF)   w_next = S_ACTIVE;
            else                           w_next = S_IDLE;
         end
         S_ACTIVE: begin
            if (w_err)                     w_next = S_ERROR;
            else if (init)                 w_next = S_INIT;
            else if (fifo_empty == 4'hF)   w_next = S_IDLE;
            else                           w_next = S_ACTIVE;
         end
         S_ERROR: w_next = S_ERROR;
         default: w_next = S_RESET;
      endcase
   end

   // State, config latch, sticky error capture and lane striping
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state   <= S_RESET;
         r_th_high <= '0;
         r_th_low  <= '0;
         r_idle    <= 1'b0;
         r_active  <= 1'b0;
         r_err     <= 4'h0;
         r_valid   <= 4'h0;
         r_data    <= '0;
         r_lane    <= 2'd0;
      end else begin
         r_state  <= w_next;
         r_idle   <= (w_next == S_IDLE);
         r_active <= (w_next == S_ACTIVE);
         if (r_state == S_INIT) begin
            r_th_high <= th_high_in;
            r_th_low  <= th_low_in;
         end
         if (r_state != S_RESET)
            r_err <= r_err | fifo_error;
         if (w_accept) begin
            r_data  <= data_in;
            r_valid <= 4'b0001 << r_lane;
            r_lane  <= r_lane + 2'd1;
         end else begin
            r_valid <= 4'h0;
            if (r_state == S_INIT)
               r_lane <= 2'd0;
         end
      end
   end

   assign state       = r_state;
   assign th_high_out = r_th_high;
   assign th_low_out  = r_th_low;
   assign idle_out    = r_idle;
   assign active_out  = r_active;
   assign error_out   = r_err;
   assign valid_out   = r_valid;
   assign data_out    = r_data;
   assign lane_sel    = r_lane;

endmodule

// File: tb/tb_fsm_striping_ctrl.sv
// Bench for fsm_striping_ctrl.
// Vector table driven through an expected-result queue.
module tb_fsm_striping_ctrl;

   localparam int DATA_W = 8;
   localparam int TH_W   = 3;

   logic              clk;
   logic              reset;
   logic              init;
   logic [TH_W-1:0]   th_high_in;
   logic [TH_W-1:0]   th_low_in;
   logic [3:0]        fifo_empty;
   logic [3:0]        fifo_error;
   logic              valid_in;
   logic [DATA_W-1:0] data_in;
   logic [TH_W-1:0]   th_high_out;
   logic [TH_W-1:0]   th_low_out;
   logic [2:0]        state;
   logic              idle_out;
   logic              active_out;
   logic [3:0]        error_out;
   logic [3:0]        valid_out;
   logic [DATA_W-1:0] data_out;
   logic [1:0]        lane_sel;

   fsm_striping_ctrl #(.DATA_W(DATA_W), .TH_W(TH_W)) dut (
      .clk(clk), .reset(reset), .init(init),
      .th_high_in(th_high_in), .th_low_in(th_low_in),
      .fifo_empty(fifo_empty), .fifo_error(fifo_error),
      .valid_in(valid_in), .data_in(data_in),
      .th_high_out(th_high_out), .th_low_out(th_low_out),
      .state(state), .idle_out(idle_out), .active_out(active_out),
      .error_out(error_out), .valid_out(valid_out),
      .data_out(data_out), .lane_sel(lane_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       ini;
      logic [2:0] thh;
      logic [2:0] thl;
      logic [3:0] emp;
      logic [3:0] err;
      logic       vin;
      logic [7:0] din;
      logic [2:0] e_st;
      logic       e_idl;
      logic       e_act;
      logic [3:0] e_eo;
      logic [3:0] e_vo;
      logic [7:0] e_do;
      logic [1:0] e_ln;
      logic [2:0] e_thh;
      logic [2:0] e_thl;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   n_vec;
   int   n_bad;

   function automatic void add(
      input logic rst, input logic ini,
      input logic [2:0] thh, input logic [2:0] thl,
      input logic [3:0] emp, input logic [3:0] err,
      input logic vin, input logic [7:0] din,
      input logic [2:0] st, input logic idl, input logic act,
      input logic [3:0] eo, input logic [3:0] vo,
      input logic [7:0] dd, input logic [1:0] ln,
      input logic [2:0] eth, input logic [2:0] etl);
      vec_t v;
      v.rst = rst; v.ini = ini; v.thh = thh; v.thl = thl;
      v.emp = emp; v.err = err; v.vin = vin; v.din = din;
      v.e_st = st; v.e_idl = idl; v.e_act = act; v.e_eo = eo;
      v.e_vo = vo; v.e_do = dd; v.e_ln = ln;
      v.e_thh = eth; v.e_thl = etl;
      tbl.push_back(v);
   endfunction

   task automatic apply(input vec_t v);
      vec_t e;
      reset      = v.rst;
      init       = v.ini;
      th_high_in = v.thh;
      th_low_in  = v.thl;
      fifo_empty = v.emp;
      fifo_error = v.err;
      valid_in   = v.vin;
      data_in    = v.din;
      sb.push_back(v);
      @(posedge clk);
      #1;
      n_vec++;
      if (sb.size() == 0) begin
         n_bad++;
         $display("FAIL vec%0d: scoreboard empty", n_vec);
      end else begin
         e = sb.pop_front();
         if (state !== e.e_st || idle_out !== e.e_idl ||
             active_out !== e.e_act || error_out !== e.e_eo ||
             valid_out !== e.e_vo || data_out !== e.e_do ||
             lane_sel !== e.e_ln || th_high_out !== e.e_thh ||
             th_low_out !== e.e_thl) begin
            n_bad++;
            $display({"FAIL vec%0d: got st=%0d idl=%b act=%b eo=%h",
                      " vo=%h do=%h ln=%0d th=%0d/%0d; want st=%0d",
                      " idl=%b act=%b eo=%h vo=%h do=%h ln=%0d th=%0d/%0d"},
                     n_vec, state, idle_out, active_out, error_out,
                     valid_out, data_out, lane_sel, th_high_out,
                     th_low_out, e.e_st, e.e_idl, e.e_act, e.e_eo,
                     e.e_vo, e.e_do, e.e_ln, e.e_thh, e.e_thl);
         end
      end
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      reset = 1'b0; init = 1'b0;
      th_high_in = '0; th_low_in = '0;
      fifo_empty = 4'hF; fifo_error = 4'h0;
      valid_in = 1'b0; data_in = '0;

      // reset, error/bytes ignored while held in reset
      add(0,0,0,0,4'hF,4'h0,0,8'h00, 0,0,0,4'h0,4'h0,8'h00,0,0,0);
      add(0,0,0,0,4'hF,4'hF,1,8'h55, 0,0,0,4'h0,4'h0,8'h00,0,0,0);
      // configure; error flag ignored in RESET state
      add(1,1,6,1,4'hF,4'h2,1,8'h99, 1,0,0,4'h0,4'h0,8'h00,0,0,0);
      add(1,1,6,1,4'hF,4'h0,1,8'h98, 1,0,0,4'h0,4'h0,8'h00,0,6,1);
      add(1,1,6,1,4'hF,4'h0,0,8'h00, 1,0,0,4'h0,4'h0,8'h00,0,6,1);
      add(1,0,6,1,4'hF,4'h0,0,8'h00, 2,1,0,4'h0,4'h0,8'h00,0,6,1);
      // round-robin, thresholds hold outside INIT
      add(1,0,7,3,4'hF,4'h0,1,8'hA0, 2,1,0,4'h0,4'h1,8'hA0,1,6,1);
      add(1,0,7,3,4'hF,4'h0,1,8'hA1, 2,1,0,4'h0,4'h2,8'hA1,2,6,1);
      add(1,0,7,3,4'hF,4'h0,1,8'hA2, 2,1,0,4'h0,4'h4,8'hA2,3,6,1);
      add(1,0,7,3,4'hF,4'h0,1,8'hA3, 2,1,0,4'h0,4'h8,8'hA3,0,6,1);
      add(1,0,7,3,4'hF,4'h0,1,8'hA4, 2,1,0,4'h0,4'h1,8'hA4,1,6,1);
      add(1,0,7,3,4'hF,4'h0,1,8'hA5, 2,1,0,4'h0,4'h2,8'hA5,2,6,1);
      // re-init clears lane position
      add(1,1,6,1,4'hF,4'h0,0,8'h00, 1,0,0,4'h0,4'h0,8'hA5,2,6,1);
      add(1,0,6,1,4'hF,4'h0,0,8'h00, 2,1,0,4'h0,4'h0,8'hA5,0,6,1);
      // gaps, init with a byte, drop in INIT
      add(1,0,6,1,4'hF,4'h0,1,8'h11, 2,1,0,4'h0,4'h1,8'h11,1,6,1);
      add(1,0,6,1,4'hF,4'h0,0,8'hFF, 2,1,0,4'h0,4'h0,8'h11,1,6,1);
      add(1,0,6,1,4'hF,4'h0,1,8'h22, 2,1,0,4'h0,4'h2,8'h22,2,6,1);
      add(1,1,6,1,4'hF,4'h0,1,8'h33, 1,0,0,4'h0,4'h4,8'h33,3,6,1);
      add(1,1,6,1,4'hF,4'h0,1,8'h44, 1,0,0,4'h0,4'h0,8'h33,0,6,1);
      add(1,0,6,1,4'hF,4'h0,0,8'h00, 2,1,0,4'h0,4'h0,8'h33,0,6,1);
      // active/idle tracking
      add(1,0,6,1,4'hD,4'h0,0,8'h00, 3,0,1,4'h0,4'h0,8'h33,0,6,1);
      add(1,0,6,1,4'hD,4'h0,1,8'hB0, 3,0,1,4'h0,4'h1,8'hB0,1,6,1);
      add(1,0,6,1,4'hF,4'h0,0,8'h00, 2,1,0,4'h0,4'h0,8'hB0,1,6,1);
      add(1,0,6,1,4'hE,4'h0,0,8'h00, 3,0,1,4'h0,4'h0,8'hB0,1,6,1);
      // error beats init, byte still striped, sticky capture
      add(1,1,6,1,4'hE,4'h4,1,8'hC0, 4,0,0,4'h4,4'h2,8'hC0,2,6,1);
      add(1,1,7,3,4'hE,4'h1,1,8'hC1, 4,0,0,4'h5,4'h0,8'hC0,2,6,1);
      add(1,0,7,3,4'hF,4'h0,1,8'hC2, 4,0,0,4'h5,4'h0,8'hC0,2,6,1);
      add(0,0,6,1,4'hF,4'h0,0,8'h00, 0,0,0,4'h0,4'h0,8'h00,0,0,0);

      foreach (tbl[i]) apply(tbl[i]);
      tbl.delete();

      // reset dropped in the middle of a continuous byte stream
      begin
         logic [2:0] st_e [10] = '{1,2,2,2,2,0,1,2,2,2};
         logic [3:0] vo_e [10] = '{0,0,1,2,4,0,0,0,1,2};
         logic [7:0] do_e [10] = '{8'h00,8'h00,8'h62,8'h63,8'h64,
                                   8'h00,8'h00,8'h00,8'h68,8'h69};
         logic [1:0] ln_e [10] = '{0,0,1,2,3,0,0,0,1,2};
         logic [2:0] th_e [10] = '{0,6,6,6,6,0,0,6,6,6};
         logic [2:0] tl_e [10] = '{0,1,1,1,1,0,0,1,1,1};
         for (int i = 0; i < 10; i++) begin
            add((i == 5) ? 1'b0 : 1'b1, 1'b0, 3'd6, 3'd1, 4'hF, 4'h0,
                1'b1, 8'h60 + 8'(i), st_e[i], (st_e[i] == 3'd2),
                1'b0, 4'h0, vo_e[i], do_e[i], ln_e[i],
                th_e[i], tl_e[i]);
         end
      end
      foreach (tbl[i]) apply(tbl[i]);

      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard: %0d left, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
